// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction queue between fetch and dispatch.
// Fetch bundles are compacted on write; decode sees the oldest PC-contiguous
// window of up to N entries combinationally (first-word-fall-through).
module fetch_buffer #(
  parameter int unsigned N     = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [N-1:0]                 if_valid,
  input  logic [N-1:0][31:0]           if_instr,
  input  logic [N-1:0][31:0]           if_pc,
  output logic                         if_ready,
  output logic [N-1:0][31:0]           ff_instr,
  output logic [31:0]                  ff_pc,
  output logic [N-1:0]                 fetch_valid,
  input  logic [$clog2(N+1)-1:0]       dispatch_count,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned DW = $clog2(N+1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          entries [DEPTH];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [CW-1:0]   count_q;

  logic [AW-1:0]   win_idx [N];
  logic [AW-1:0]   wr_idx  [N];
  logic [DW-1:0]   wr_off  [N];
  logic [DW-1:0]   enq_cnt;
  logic [DW-1:0]   enq_add;
  logic [DW-1:0]   avail;
  logic [DW-1:0]   deq;
  logic            ready_int;
  logic            enq_fire;
  logic [31:0]     head_pc;

  // Space for a full bundle, judged on registered occupancy only.
  assign ready_int = (count_q <= CW'(DEPTH - N));
  assign if_ready  = reset | ready_int;
  assign count     = reset ? '0 : count_q;
  assign enq_fire  = ready_int && (|if_valid) && !flush && !reset;
  assign enq_add   = enq_fire ? enq_cnt : '0;
  assign head_pc   = entries[head_q].pc;

  // Compaction offsets: each valid slot lands after all lower valid slots.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < N; i++) begin
      wr_off[i]  = enq_cnt;
      wr_idx[i]  = tail_q + AW'(enq_cnt);
      enq_cnt    = enq_cnt + DW'(if_valid[i]);
    end
  end

  // Head-window ring indices; may straddle DEPTH-1 -> 0.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      win_idx[i] = head_q + AW'(i);
    end
  end

  // Head window: valid run stops at occupancy limit or first PC break.
  always_comb begin
    fetch_valid = '0;
    ff_instr    = '0;
    ff_pc       = '0;
    if (!reset && (count_q != '0)) begin
      fetch_valid[0] = 1'b1;
      ff_pc          = head_pc;
      for (int i = 1; i < N; i++) begin
        fetch_valid[i] = fetch_valid[i-1] && (CW'(i) < count_q) &&
                         (entries[win_idx[i]].pc == head_pc + 32'(4 * i));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (fetch_valid[i]) ff_instr[i] = entries[win_idx[i]].instr;
    end
  end

  // Dequeue amount, clamped to what the window actually offers.
  always_comb begin
    avail = '0;
    for (int i = 0; i < N; i++) begin
      avail = avail + DW'(fetch_valid[i]);
    end
    deq = (dispatch_count > avail) ? avail : dispatch_count;
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      for (int i = 0; i < N; i++) begin
        if (if_valid[i]) begin
          entries[wr_idx[i]].instr <= if_instr[i];
          entries[wr_idx[i]].pc    <= if_pc[i];
        end
      end
    end
  end

  // Pointers and occupancy; reset beats flush, flush beats enq/deq.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + AW'(deq);
      tail_q  <= tail_q + AW'(enq_add);
      count_q <= count_q + CW'(enq_add) - CW'(deq);
    end
  end

  // Dispatch may never retire more than the window presents.
  dispatch_le_avail: assert property (@(posedge clock) disable iff (reset || flush)
                                      dispatch_count <= avail);

  logic unused_ok;
  assign unused_ok = |wr_off[0];

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (N=3, DEPTH=8).
module tb_fetch_buffer;

  localparam int unsigned N     = 3;
  localparam int unsigned DEPTH = 8;

  logic              clock;
  logic              reset;
  logic              flush;
  logic [N-1:0]      if_valid;
  logic [N-1:0][31:0] if_instr;
  logic [N-1:0][31:0] if_pc;
  logic              if_ready;
  logic [N-1:0][31:0] ff_instr;
  logic [31:0]       ff_pc;
  logic [N-1:0]      fetch_valid;
  logic [1:0]        dispatch_count;
  logic [3:0]        count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fetch_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .ff_instr       (ff_instr),
    .ff_pc          (ff_pc),
    .fetch_valid    (fetch_valid),
    .dispatch_count (dispatch_count),
    .count          (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction word is the inverted PC so contents are easy to predict.
  task automatic set_bundle(input logic [2:0] v, input logic [31:0] p0,
                            input logic [31:0] p1, input logic [31:0] p2);
    if_valid = v;
    if_pc    = {p2, p1, p0};
    if_instr = {~p2, ~p1, ~p0};
  endtask

  // One clock; sample point is 1ns after the edge, inputs then go idle.
  task automatic cycle();
    @(posedge clock);
    #1;
    if_valid       = '0;
    dispatch_count = '0;
    flush          = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; if_valid = '0; if_pc = '0; if_instr = '0;
    dispatch_count = '0;
    cycle();
    cycle();
    total_cnt++; if (fetch_valid !== 3'b000) $display("FAIL reset_fv got %b exp 000", fetch_valid); else pass_cnt++;
    total_cnt++; if (ff_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", ff_pc); else pass_cnt++;
    total_cnt++; if (ff_instr !== 96'h0) $display("FAIL reset_instr got %h exp 0", ff_instr); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", if_ready); else pass_cnt++;
    total_cnt++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    set_bundle(3'b111, 32'h0, 32'h4, 32'h8);
    cycle();
    total_cnt++; if (fetch_valid !== 3'b111) $display("FAIL basic_fv got %b exp 111", fetch_valid); else pass_cnt++;
    total_cnt++; if (ff_pc !== 32'h0) $display("FAIL basic_pc got %h exp 0", ff_pc); else pass_cnt++;
    total_cnt++; if (count !== 4'd3) $display("FAIL basic_count got %0d exp 3", count); else pass_cnt++;
    total_cnt++; if (ff_instr !== {~32'h8, ~32'h4, ~32'h0}) $display("FAIL basic_instr got %h", ff_instr); else pass_cnt++;
    dispatch_count = 2'd2;
    cycle();
    total_cnt++; if (count !== 4'd1) $display("FAIL basic_deq_count got %0d exp 1", count); else pass_cnt++;
    total_cnt++; if (ff_pc !== 32'h8) $display("FAIL basic_deq_pc got %h exp 8", ff_pc); else pass_cnt++;
    total_cnt++; if (fetch_valid !== 3'b001) $display("FAIL basic_deq_fv got %b exp 001", fetch_valid); else pass_cnt++;
    total_cnt++; if (ff_instr !== {32'h0, 32'h0, ~32'h8}) $display("FAIL basic_deq_instr got %h", ff_instr); else pass_cnt++;
    dispatch_count = 2'd1;
    cycle();
    total_cnt++; if (count !== 4'd0) $display("FAIL basic_drain got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_compact();
    flush = 1'b1;
    cycle();
    set_bundle(3'b101, 32'h10, 32'hDEAD, 32'h14);
    cycle();
    total_cnt++; if (fetch_valid !== 3'b011) $display("FAIL compact_fv got %b exp 011", fetch_valid); else pass_cnt++;
    total_cnt++; if (ff_instr[1] !== ~32'h14) $display("FAIL compact_slot1 got %h exp %h", ff_instr[1], ~32'h14); else pass_cnt++;
    total_cnt++; if (ff_instr[0] !== ~32'h10) $display("FAIL compact_slot0 got %h exp %h", ff_instr[0], ~32'h10); else pass_cnt++;
    total_cnt++; if (count !== 4'd2) $display("FAIL compact_count got %0d exp 2", count); else pass_cnt++;
    flush = 1'b1;
    cycle();
    total_cnt++; if (count !== 4'd0) $display("FAIL compact_flush got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_full();
    set_bundle(3'b111, 32'h100, 32'h104, 32'h108);
    cycle();
    set_bundle(3'b111, 32'h10C, 32'h110, 32'h114);
    cycle();
    total_cnt++; if (count !== 4'd6) $display("FAIL full6_count got %0d exp 6", count); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL full6_ready got %b exp 0", if_ready); else pass_cnt++;
    set_bundle(3'b111, 32'h200, 32'h204, 32'h208);
    cycle();
    total_cnt++; if (count !== 4'd6) $display("FAIL full6_hold got %0d exp 6", count); else pass_cnt++;
    total_cnt++; if (ff_pc !== 32'h100) $display("FAIL full6_pc got %h exp 100", ff_pc); else pass_cnt++;
    dispatch_count = 2'd3;
    cycle();
    total_cnt++; if (count !== 4'd3) $display("FAIL full_deq_count got %0d exp 3", count); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL full_deq_ready got %b exp 1", if_ready); else pass_cnt++;
    total_cnt++; if (ff_pc !== 32'h10C) $display("FAIL full_deq_pc got %h exp 10c", ff_pc); else pass_cnt++;
    dispatch_count = 2'd3;
    cycle();
    // Reach count == DEPTH with a partial bundle: 3 + 2 + 3.
    set_bundle(3'b111, 32'h500, 32'h504, 32'h508);
    cycle();
    set_bundle(3'b011, 32'h50C, 32'h510, 32'hBEEF);
    cycle();
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL full5_ready got %b exp 1", if_ready); else pass_cnt++;
    set_bundle(3'b111, 32'h514, 32'h518, 32'h51C);
    cycle();
    total_cnt++; if (count !== 4'd8) $display("FAIL full8_count got %0d exp 8", count); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL full8_ready got %b exp 0", if_ready); else pass_cnt++;
    total_cnt++; if (ff_instr !== {~32'h508, ~32'h504, ~32'h500}) $display("FAIL full8_instr got %h", ff_instr); else pass_cnt++;
    flush = 1'b1;
    cycle();
  endtask

  task automatic test_discontinuity();
    set_bundle(3'b111, 32'h20, 32'h24, 32'h100);
    cycle();
    total_cnt++; if (fetch_valid !== 3'b011) $display("FAIL disc_fv got %b exp 011", fetch_valid); else pass_cnt++;
    total_cnt++; if (ff_instr[2] !== 32'h0) $display("FAIL disc_slot2 got %h exp 0", ff_instr[2]); else pass_cnt++;
    dispatch_count = 2'd2;
    cycle();
    total_cnt++; if (ff_pc !== 32'h100) $display("FAIL disc_pc got %h exp 100", ff_pc); else pass_cnt++;
    total_cnt++; if (fetch_valid !== 3'b001) $display("FAIL disc_fv2 got %b exp 001", fetch_valid); else pass_cnt++;
    dispatch_count = 2'd1;
    cycle();
  endtask

  task automatic test_wrap();
    // head/tail start at 3; move both to 6.
    set_bundle(3'b111, 32'h300, 32'h304, 32'h308);
    cycle();
    dispatch_count = 2'd3;
    cycle();
    set_bundle(3'b111, 32'h400, 32'h404, 32'h408);
    cycle();
    set_bundle(3'b011, 32'h40C, 32'h410, 32'hBAD0);
    cycle();
    total_cnt++; if (count !== 4'd5) $display("FAIL wrap_count got %0d exp 5", count); else pass_cnt++;
    total_cnt++; if (fetch_valid !== 3'b111) $display("FAIL wrap_fv got %b exp 111", fetch_valid); else pass_cnt++;
    total_cnt++; if (ff_pc !== 32'h400) $display("FAIL wrap_pc got %h exp 400", ff_pc); else pass_cnt++;
    total_cnt++; if (ff_instr !== {~32'h408, ~32'h404, ~32'h400}) $display("FAIL wrap_instr got %h", ff_instr); else pass_cnt++;
    // Simultaneous enqueue of 3 and dequeue of 3.
    set_bundle(3'b111, 32'h414, 32'h418, 32'h41C);
    dispatch_count = 2'd3;
    cycle();
    total_cnt++; if (count !== 4'd5) $display("FAIL wrap_both_count got %0d exp 5", count); else pass_cnt++;
    total_cnt++; if (ff_pc !== 32'h40C) $display("FAIL wrap_both_pc got %h exp 40c", ff_pc); else pass_cnt++;
    total_cnt++; if (ff_instr !== {~32'h414, ~32'h410, ~32'h40C}) $display("FAIL wrap_both_instr got %h", ff_instr); else pass_cnt++;
  endtask

  task automatic test_flush();
    set_bundle(3'b111, 32'h600, 32'h604, 32'h608);
    dispatch_count = 2'd1;
    flush = 1'b1;
    cycle();
    total_cnt++; if (count !== 4'd0) $display("FAIL flush_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (fetch_valid !== 3'b000) $display("FAIL flush_fv got %b exp 000", fetch_valid); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL flush_ready got %b exp 1", if_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    set_bundle(3'b111, 32'h700, 32'h704, 32'h708);
    cycle();
    set_bundle(3'b111, 32'h70C, 32'h710, 32'h714);
    dispatch_count = 2'd1;
    reset = 1'b1;
    cycle();
    total_cnt++; if (count !== 4'd0) $display("FAIL rstmid_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (fetch_valid !== 3'b000) $display("FAIL rstmid_fv got %b exp 000", fetch_valid); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", if_ready); else pass_cnt++;
    reset = 1'b0;
    set_bundle(3'b001, 32'h800, 32'h0, 32'h0);
    cycle();
    total_cnt++; if (ff_pc !== 32'h800) $display("FAIL rstmid_new_pc got %h exp 800", ff_pc); else pass_cnt++;
    total_cnt++; if (count !== 4'd1) $display("FAIL rstmid_new_count got %0d exp 1", count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_compact();
    test_full();
    test_discontinuity();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
